// File: rtl/m68k_bus_decoder_if.sv
// Bus interface for m68k_bus_decoder: CPU strobe/address, table loader port
// and the decoder's chip-select / acknowledge outputs.
// Optional hit-counter signals are present only when BUS_DECODER_HITCNT_EN is defined.
interface m68k_bus_decoder_if #(
  parameter int unsigned NUM_REGIONS = 24,
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned WAIT_W      = 4,
  parameter int unsigned IDX_W       = 5
);

  // CPU side
  logic [ADDR_W-1:0]      m68k_a;
  logic                   m68k_as_n;

  // Table loader side
  logic                   cfg_we;
  logic [IDX_W-1:0]       cfg_idx;
  logic                   cfg_en;
  logic [ADDR_W-1:0]      cfg_base;
  logic [ADDR_W-1:0]      cfg_mask;
  logic [WAIT_W-1:0]      cfg_wait;

  // Decoder results
  logic [NUM_REGIONS-1:0] cs;
  logic [IDX_W-1:0]       region_idx;
  logic                   dtack_n;
  logic                   berr_n;
  logic                   busy;

`ifdef BUS_DECODER_HITCNT_EN
  logic [IDX_W-1:0]       hit_sel;
  logic                   hit_clr;
  logic [15:0]            hit_count;

  modport master (
    output m68k_a, m68k_as_n,
    output cfg_we, cfg_idx, cfg_en, cfg_base, cfg_mask, cfg_wait,
    output hit_sel, hit_clr,
    input  cs, region_idx, dtack_n, berr_n, busy,
    input  hit_count
  );

  modport slave (
    input  m68k_a, m68k_as_n,
    input  cfg_we, cfg_idx, cfg_en, cfg_base, cfg_mask, cfg_wait,
    input  hit_sel, hit_clr,
    output cs, region_idx, dtack_n, berr_n, busy,
    output hit_count
  );
`else
  modport master (
    output m68k_a, m68k_as_n,
    output cfg_we, cfg_idx, cfg_en, cfg_base, cfg_mask, cfg_wait,
    input  cs, region_idx, dtack_n, berr_n, busy
  );

  modport slave (
    input  m68k_a, m68k_as_n,
    input  cfg_we, cfg_idx, cfg_en, cfg_base, cfg_mask, cfg_wait,
    output cs, region_idx, dtack_n, berr_n, busy
  );
`endif

endinterface

// File: rtl/m68k_bus_decoder.sv
// Programmable 68k bus-cycle decoder: a runtime-loaded table of address windows
// (base/mask/wait), registered one-hot chip selects, programmable wait states,
// DTACK generation and bus-error timeout for unmapped accesses.
// Optional per-region saturating hit counters: define BUS_DECODER_HITCNT_EN.
module m68k_bus_decoder #(
  parameter int unsigned NUM_REGIONS    = 24,
  parameter int unsigned ADDR_W         = 24,
  parameter int unsigned WAIT_W         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned IDX_W          = 5
) (
  input  logic                clk_sys,
  input  logic                reset,
  m68k_bus_decoder_if.slave   bus
);

  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned HCNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_WAIT   = 3'd2,
    S_ACK    = 3'd3,
    S_TMO    = 3'd4,
    S_BERR   = 3'd5
  } state_e;

  state_e                 state_q, state_d;

  // Strobe synchroniser
  logic                   as_s1_q, as_s2_q;
  logic                   as_fall;
  logic                   as_high;

  // Decode table
  logic                   en_q   [NUM_REGIONS];
  logic [ADDR_W-1:0]      base_q [NUM_REGIONS];
  logic [ADDR_W-1:0]      mask_q [NUM_REGIONS];
  logic [WAIT_W-1:0]      wait_q [NUM_REGIONS];
  logic                   cfg_ok;

  // Match results
  logic [NUM_REGIONS-1:0] hit_vec;
  logic                   hit_any;
  logic [IDX_W-1:0]       hit_idx;
  logic [WAIT_W-1:0]      hit_wait;

  // Registered outputs and counters
  logic [NUM_REGIONS-1:0] cs_q, cs_d;
  logic [IDX_W-1:0]       region_idx_q, region_idx_d;
  logic                   dtack_n_q, dtack_n_d;
  logic                   berr_n_q, berr_n_d;
  logic                   busy_q, busy_d;
  logic [WAIT_W-1:0]      wcnt_q, wcnt_d;
  logic [TMO_W-1:0]       tcnt_q, tcnt_d;

  // Double-register the asynchronous address strobe
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      as_s1_q <= 1'b1;
      as_s2_q <= 1'b1;
    end else begin
      as_s1_q <= bus.m68k_as_n;
      as_s2_q <= as_s1_q;
    end
  end

  // Registered strobe level and its high-to-low transition
  assign as_high = as_s1_q;
  assign as_fall = as_s2_q & ~as_s1_q;

  // Out-of-range indices are dropped rather than aliased onto a real entry
  assign cfg_ok = bus.cfg_we && (32'(bus.cfg_idx) < NUM_REGIONS);

  // Table storage; a write lands on the next edge and never touches the latched cycle state
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        en_q[i]   <= 1'b0;
        base_q[i] <= '0;
        mask_q[i] <= '0;
        wait_q[i] <= '0;
      end
    end else if (cfg_ok) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (bus.cfg_idx == IDX_W'(i)) begin
          en_q[i]   <= bus.cfg_en;
          base_q[i] <= bus.cfg_base;
          mask_q[i] <= bus.cfg_mask;
          wait_q[i] <= bus.cfg_wait;
        end
      end
    end
  end

  // Per-window compare; a zero mask matches every address
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      hit_vec[i] = en_q[i] && ((bus.m68k_a & mask_q[i]) == (base_q[i] & mask_q[i]));
    end
  end

  // Priority select: the lowest matching index wins
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    hit_wait = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (hit_vec[i] && !hit_any) begin
        hit_any  = 1'b1;
        hit_idx  = IDX_W'(i);
        hit_wait = wait_q[i];
      end
    end
  end

  // Bus-cycle state and output registers
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cs_q         <= '0;
      region_idx_q <= '0;
      dtack_n_q    <= 1'b1;
      berr_n_q     <= 1'b1;
      busy_q       <= 1'b0;
      wcnt_q       <= '0;
      tcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      cs_q         <= cs_d;
      region_idx_q <= region_idx_d;
      dtack_n_q    <= dtack_n_d;
      berr_n_q     <= berr_n_d;
      busy_q       <= busy_d;
      wcnt_q       <= wcnt_d;
      tcnt_q       <= tcnt_d;
    end
  end

  // Bus-cycle sequencing: decode, wait states, acknowledge or timeout
  always_comb begin
    state_d      = state_q;
    cs_d         = cs_q;
    region_idx_d = region_idx_q;
    dtack_n_d    = dtack_n_q;
    berr_n_d     = berr_n_q;
    busy_d       = busy_q;
    wcnt_d       = wcnt_q;
    tcnt_d       = tcnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (as_fall) begin
          busy_d  = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (hit_any) begin
          region_idx_d = hit_idx;
          cs_d         = NUM_REGIONS'(1) << hit_idx;
          wcnt_d       = hit_wait;
          state_d      = S_WAIT;
        end else begin
          tcnt_d  = '0;
          state_d = S_TMO;
        end
      end

      S_WAIT: begin
        if (as_high) begin
          // CPU gave up on the cycle: drop the select without acknowledging
          cs_d    = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (wcnt_q == '0) begin
          dtack_n_d = 1'b0;
          state_d   = S_ACK;
        end else begin
          wcnt_d = wcnt_q - WAIT_W'(1);
        end
      end

      S_ACK: begin
        if (as_high) begin
          cs_d      = '0;
          dtack_n_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end
      end

      S_TMO: begin
        if (as_high) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (tcnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          berr_n_d = 1'b0;
          state_d  = S_BERR;
        end else begin
          tcnt_d = tcnt_q + TMO_W'(1);
        end
      end

      S_BERR: begin
        if (as_high) begin
          berr_n_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.cs         = cs_q;
  assign bus.region_idx = region_idx_q;
  assign bus.dtack_n    = dtack_n_q;
  assign bus.berr_n     = berr_n_q;
  assign bus.busy       = busy_q;

`ifdef BUS_DECODER_HITCNT_EN
  logic [HCNT_W-1:0] hcnt_q [NUM_REGIONS];
  logic              ack_entry;
  logic [HCNT_W-1:0] hit_count_c;

  assign ack_entry = (state_q == S_WAIT) && (state_d == S_ACK);

  // Saturating per-region hit counters; clear wins over a same-cycle increment
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        hcnt_q[i] <= '0;
      end
    end else if (bus.hit_clr) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        hcnt_q[i] <= '0;
      end
    end else if (ack_entry) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if ((region_idx_q == IDX_W'(i)) && (hcnt_q[i] != {HCNT_W{1'b1}})) begin
          hcnt_q[i] <= hcnt_q[i] + HCNT_W'(1);
        end
      end
    end
  end

  // Combinational read-back; out-of-range selects read as zero
  always_comb begin
    hit_count_c = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (bus.hit_sel == IDX_W'(i)) begin
        hit_count_c = hcnt_q[i];
      end
    end
  end

  assign bus.hit_count = hit_count_c;
`endif

endmodule

// File: tb/tb_m68k_bus_decoder.sv
// Testbench for m68k_bus_decoder: directed scenarios followed by randomized
// table loads and accesses, checked against a window-table reference model.
module tb_m68k_bus_decoder;

  localparam int unsigned NR  = 24;
  localparam int unsigned AW  = 24;
  localparam int unsigned WW  = 4;
  localparam int unsigned TMO = 64;
  localparam int unsigned IW  = 5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  m68k_bus_decoder_if #(.NUM_REGIONS(NR), .ADDR_W(AW), .WAIT_W(WW), .IDX_W(IW)) bus ();

  m68k_bus_decoder #(
    .NUM_REGIONS(NR), .ADDR_W(AW), .WAIT_W(WW), .TIMEOUT_CYCLES(TMO), .IDX_W(IW)
  ) dut (
    .clk_sys (clk),
    .reset   (rst),
    .bus     (bus)
  );

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_viol = 0;

  // Reference model: the window table and expected hit counts
  bit          m_en   [NR];
  logic [AW-1:0] m_base [NR];
  logic [AW-1:0] m_mask [NR];
  int          m_wait [NR];
  int          m_hits [NR];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin
      m_en[i] = 1'b0; m_base[i] = '0; m_mask[i] = '0; m_wait[i] = 0; m_hits[i] = 0;
    end
  endfunction

  function automatic void model_apply(input int idx, input bit en, input logic [AW-1:0] base,
                                      input logic [AW-1:0] mask, input int w);
    if (idx < int'(NR)) begin
      m_en[idx] = en; m_base[idx] = base; m_mask[idx] = mask; m_wait[idx] = w;
    end
  endfunction

  // First enabled window whose masked bits agree with the address; -1 if none
  function automatic void lookup(input logic [AW-1:0] a, output int idx, output int w);
    idx = -1; w = 0;
    for (int i = 0; i < NR; i++) begin
      if (idx < 0 && m_en[i] && (((a ^ m_base[i]) & m_mask[i]) == '0)) begin
        idx = i; w = m_wait[i];
      end
    end
  endfunction

  task automatic drive_cfg(input int idx, input bit en, input logic [AW-1:0] base,
                           input logic [AW-1:0] mask, input int w);
    bus.cfg_idx  = IW'(idx);
    bus.cfg_en   = en;
    bus.cfg_base = base;
    bus.cfg_mask = mask;
    bus.cfg_wait = WW'(w);
    bus.cfg_we   = 1'b1;
  endtask

  task automatic cfg_write(input int idx, input bit en, input logic [AW-1:0] base,
                           input logic [AW-1:0] mask, input int w);
    @(posedge clk); #1;
    drive_cfg(idx, en, base, mask, w);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    model_apply(idx, en, base, mask, w);
  endtask

  // One complete bus cycle; edge n counts posedges after as_n was driven low
  task automatic access(input logic [AW-1:0] addr, input bit abort, input bit mid_wr);
    int exp_idx, exp_w, lat_d, lat_b;
    bit do_abort;
    logic [NR-1:0] cs3;
    logic [IW-1:0] ri3;
    logic busy3;
    int mw_idx, mw_w;
    bit mw_en;
    logic [AW-1:0] mw_base, mw_mask;

    lookup(addr, exp_idx, exp_w);
    do_abort = abort && ((exp_idx >= 0 && exp_w >= 3) || exp_idx < 0);
    mw_idx  = int'($urandom_range(0, 31));
    mw_en   = 1'($urandom);
    mw_base = AW'($urandom);
    mw_mask = AW'($urandom);
    mw_w    = int'($urandom_range(0, 15));
    cs3 = '0; ri3 = '0; busy3 = 1'b0;
    lat_d = -1; lat_b = -1;

    @(posedge clk); #1;
    bus.m68k_a    = addr;
    bus.m68k_as_n = 1'b0;
    for (int n = 1; n <= int'(TMO) + 20; n++) begin
      @(posedge clk); #1;
      if (n == 3) begin
        cs3 = bus.cs; ri3 = bus.region_idx; busy3 = bus.busy;
        if (mid_wr) drive_cfg(mw_idx, mw_en, mw_base, mw_mask, mw_w);
      end
      if (mid_wr && n == 4) begin
        bus.cfg_we = 1'b0;
        model_apply(mw_idx, mw_en, mw_base, mw_mask, mw_w);
      end
      if (bus.dtack_n == 1'b0 && lat_d < 0) lat_d = n;
      if (bus.berr_n == 1'b0 && lat_b < 0) lat_b = n;
      if (do_abort && exp_idx >= 0 && n == 3) bus.m68k_as_n = 1'b1;
      if (do_abort && exp_idx < 0 && n == 10) bus.m68k_as_n = 1'b1;
      if (do_abort && n == 12) break;
      if (!do_abort && (lat_d > 0 || lat_b > 0)) break;
    end

    chk("busy_in_cycle", longint'(busy3), 1);
    if (exp_idx >= 0) begin
      chk("cs_onehot", longint'(cs3), longint'(1) << exp_idx);
      chk("region_idx", longint'(ri3), longint'(exp_idx));
    end else begin
      chk("cs_on_miss", longint'(cs3), 0);
    end

    if (do_abort) begin
      chk("abort_no_dtack", longint'(lat_d), -1);
      chk("abort_no_berr", longint'(lat_b), -1);
      chk("abort_cs", longint'(bus.cs), 0);
      chk("abort_busy", longint'(bus.busy), 0);
      @(posedge clk); #1;
    end else begin
      if (exp_idx >= 0) begin
        chk("dtack_latency", longint'(lat_d), longint'(4 + exp_w));
        chk("berr_on_hit", longint'(lat_b), -1);
        m_hits[exp_idx]++;
      end else begin
        chk("berr_latency", longint'(lat_b), longint'(3 + int'(TMO)));
        chk("dtack_on_miss", longint'(lat_d), -1);
      end
      bus.m68k_as_n = 1'b1;
      @(posedge clk); #1;
      chk("ack_held", longint'(bus.dtack_n & bus.berr_n), 0);
      @(posedge clk); #1;
      chk("release_dtack", longint'(bus.dtack_n), 1);
      chk("release_berr", longint'(bus.berr_n), 1);
      chk("release_cs", longint'(bus.cs), 0);
      chk("release_busy", longint'(bus.busy), 0);
      @(posedge clk); #1;
    end
  endtask

  // Output invariants watched on every falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if ($countones(bus.cs) > 1) n_viol++;
      if (!bus.dtack_n && !bus.berr_n) n_viol++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    int k;

    rst = 1'b1;
    bus.m68k_a = '0; bus.m68k_as_n = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_en = 1'b0;
    bus.cfg_base = '0; bus.cfg_mask = '0; bus.cfg_wait = '0;
`ifdef BUS_DECODER_HITCNT_EN
    bus.hit_sel = '0; bus.hit_clr = 1'b0;
`endif
    model_reset();

    #23;
    chk("rst_cs", longint'(bus.cs), 0);
    chk("rst_region_idx", longint'(bus.region_idx), 0);
    chk("rst_dtack_n", longint'(bus.dtack_n), 1);
    chk("rst_berr_n", longint'(bus.berr_n), 1);
    chk("rst_busy", longint'(bus.busy), 0);
    rst = 1'b0;

    // Basic windows, wait 0 and wait 2
    cfg_write(0, 1'b1, 24'h000000, 24'hFA0000, 0);
    cfg_write(1, 1'b1, 24'h060000, 24'hFFC000, 2);
    access(24'h060010, 1'b0, 1'b0);
    access(24'h04FFFE, 1'b0, 1'b0);

    // Overlap: a catch-all at a higher index loses to region 1
    cfg_write(2, 1'b1, 24'h060000, 24'h000000, 5);
    access(24'h060010, 1'b0, 1'b0);

    // Unmapped access times out; out-of-range index write must not alias
    cfg_write(2, 1'b0, 24'h060000, 24'h000000, 5);
    cfg_write(25, 1'b1, 24'h0F0000, 24'hFF0000, 7);
    access(24'h0F0000, 1'b0, 1'b0);
    access(24'h0F0000, 1'b1, 1'b0);

    // Early strobe release inside wait states
    cfg_write(3, 1'b1, 24'h100000, 24'hFF0000, 15);
    access(24'h100004, 1'b1, 1'b0);

    // Reset in the middle of a long wait
    @(posedge clk); #1;
    bus.m68k_a = 24'h100004; bus.m68k_as_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_reset_cs", longint'(bus.cs), longint'(1) << 3);
    #2 rst = 1'b1;
    #1;
    chk("midrst_cs", longint'(bus.cs), 0);
    chk("midrst_dtack_n", longint'(bus.dtack_n), 1);
    chk("midrst_busy", longint'(bus.busy), 0);
    bus.m68k_as_n = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    access(24'h060010, 1'b0, 1'b0);

`ifdef BUS_DECODER_HITCNT_EN
    cfg_write(1, 1'b1, 24'h060000, 24'hFFC000, 2);
    repeat (3) access(24'h060010, 1'b0, 1'b0);
    bus.hit_sel = IW'(1); #1;
    chk("hit_count_3", longint'(bus.hit_count), 3);
    @(posedge clk); #1; bus.hit_clr = 1'b1;
    @(posedge clk); #1; bus.hit_clr = 1'b0;
    chk("hit_count_clr", longint'(bus.hit_count), 0);
    for (int i = 0; i < NR; i++) m_hits[i] = 0;
`endif

    // Randomized table and traffic
    for (int i = 0; i < NR; i++) begin
      logic [AW-1:0] mk;
      case ($urandom_range(0, 3))
        0: mk = 24'hFF0000;
        1: mk = 24'hFFF000;
        2: mk = 24'hF80000;
        default: mk = 24'hFFFFF0;
      endcase
      if (i == int'(NR) - 1 && $urandom_range(0, 1) == 1) mk = '0;
      cfg_write(i, ($urandom_range(0, 3) != 0), AW'($urandom), mk, int'($urandom_range(0, 15)));
    end
    cfg_write(int'($urandom_range(NR, 31)), 1'b1, '0, '0, 0);

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        a = AW'($urandom);
      end else begin
        k = int'($urandom_range(0, NR - 1));
        a = (m_base[k] & m_mask[k]) | (AW'($urandom) & ~m_mask[k]);
      end
      if ($urandom_range(0, 9) == 0)
        cfg_write(int'($urandom_range(0, 31)), 1'($urandom), AW'($urandom), 24'hFFF000,
                  int'($urandom_range(0, 15)));
      access(a, ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
    end

    chk("invariants", longint'(n_viol), 0);

`ifdef BUS_DECODER_HITCNT_EN
    for (int i = 0; i < 32; i++) begin
      bus.hit_sel = IW'(i); #1;
      chk("hit_count_final", longint'(bus.hit_count), (i < int'(NR)) ? longint'(m_hits[i]) : 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/m68k_bus_decoder.md
Name: m68k_bus_decoder

Overview:
- Parametrised, programmable successor to the fixed per-PCB chip-select decode.
- Holds a runtime-loadable table of NUM_REGIONS address windows, each defined by base, mask and wait-state count, written by the loader at core start.
- Sequences each 68k bus cycle: registered one-hot chip-select, programmable wait states, then DTACK; issues bus error when no window matches within a timeout.
- Sits between the 68k core and all memory/IO blocks, replacing per-PCB case tables.

Parameters:
- NUM_REGIONS, 24, number of decode windows (1..32).
- ADDR_W, 24, compared address width.
- WAIT_W, 4, wait-state counter width (0..2^WAIT_W-1 extra cycles).
- TIMEOUT_CYCLES, 64, clocks before bus error on unmapped access (>=2).
- IDX_W, 5, width of the region index (>= clog2(NUM_REGIONS)).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- m68k_a  in  ADDR_W  CPU byte address.
- m68k_as_n  in  1  address strobe, active low.
- cfg_we  in  1  write one table entry this cycle.
- cfg_idx  in  IDX_W  entry index.
- cfg_en  in  1  entry enable.
- cfg_base  in  ADDR_W  entry base.
- cfg_mask  in  ADDR_W  entry compare mask (1 = bit compared).
- cfg_wait  in  WAIT_W  entry wait states.
- cs  out  NUM_REGIONS  registered one-hot chip selects.
- region_idx  out  IDX_W  index of the active region.
- dtack_n  out  1  data acknowledge to CPU, active low.
- berr_n  out  1  bus error to CPU, active low.
- busy  out  1  bus cycle in progress.

Behaviour:
- Reset values: all table entries disabled (base/mask/wait = 0); cs = 0; region_idx = 0; dtack_n = 1; berr_n = 1; busy = 0; FSM = IDLE. Reset takes effect immediately, including mid-cycle.
- Match rule: hit[i] = en[i] && ((m68k_a & mask[i]) == (base[i] & mask[i])). The lowest matching index wins. A mask of 0 matches every address.
- Config writes:
  - Take effect on the next clock edge.
  - cfg_idx >= NUM_REGIONS is ignored.
  - A write during a bus cycle does not alter the latched region of that cycle.
- The as_n input is double-registered; a cycle starts on a registered high-to-low transition.
- FSM:
  - IDLE: on as_n falling, go to DECODE; busy = 1.
  - DECODE (1 clk): evaluate the match.
    - On a hit: latch the index into region_idx, set cs[idx] = 1, load the wait counter with wait[idx], go to WAIT.
    - On no hit: clear the timeout counter, go to TMO.
  - WAIT: decrement the counter each clock. When the counter is 0, dtack_n = 0 and go to ACK. With wait = 0, dtack_n asserts on the clock after DECODE.
  - ACK: hold cs and dtack_n until registered as_n = 1. Then cs = 0, dtack_n = 1, busy = 0, go to IDLE.
  - TMO: count clocks. At TIMEOUT_CYCLES-1, berr_n = 0 and go to BERR. If as_n rises before that, return to IDLE with no error.
  - BERR: hold berr_n low until as_n = 1, then go to IDLE.
- If as_n rises early in WAIT: abort, deassert cs, no dtack, go to IDLE.
- Latency from as_n low at the pin to dtack_n low = 2 (sync) + 1 (DECODE) + wait + 1 clocks.
- Invariants:
  - cs is at most one-hot at all times.
  - dtack_n and berr_n are never low together.
  - The counter does not wrap; it is loaded only in DECODE.

Optional Feature:
- Macro: BUS_DECODER_HITCNT_EN.
- When defined:
  - Add inputs hit_sel (IDX_W) and hit_clr (1), and output hit_count (16).
  - Each region keeps a 16-bit saturating counter, incremented on entry to ACK for that region and held at 16'hFFFF once reached.
  - hit_count = counter[hit_sel], combinational; 0 if hit_sel is out of range.
  - hit_clr zeroes all counters on the next clock and takes priority over a same-cycle increment.
  - Reset clears all counters.
- When undefined: these ports and counters do not exist, and the behaviour above is unchanged.

Test Plan:
1. Load region 0 = base 24'h000000, mask 24'hFA0000, wait 0; region 1 = base 24'h060000, mask 24'hFFC000, wait 2. Access 24'h060010 -> cs = 2'b10, region_idx = 1, dtack_n low exactly 3 clocks after DECODE; released 1 clock after as_n high.
2. Access 24'h04FFFE -> cs[0] = 1, dtack_n low on the clock after DECODE.
3. Overlap priority: region 2 = base 24'h060000, mask 0. Access 24'h060010 -> region 1 wins, not region 2.
4. Access 24'h0F0000 with TIMEOUT_CYCLES = 64 -> berr_n low 64 clocks after DECODE, dtack_n stays 1; as_n high -> berr_n = 1, busy = 0.
5. Assert reset during WAIT of a wait = 15 region -> cs = 0, dtack_n = 1, busy = 0 immediately; the table reads back all entries disabled (the next access times out).
6. With BUS_DECODER_HITCNT_EN: 3 accesses to region 1, then hit_sel = 1 -> hit_count = 3; pulse hit_clr -> 0; preload 16'hFFFF via repeated accesses -> stays 16'hFFFF.
